midi_voice_trigger: RTL
=======================

// Module: midi_voice_trigger
// PURPOSE
//  MIDI channel-voice parser that drives adsr_mngt for one monophonic voice.
//  Consumes raw MIDI bytes from the UART receiver.
//  Produces the single-cycle new_note_pulse / release_note_pulse that adsr_mngt expects, plus note and velocity.
//  Produces attack/decay/release/sustain settings taken from Control Change messages.
// PARAMETERS
//  MIDI_CH      4'd0     channel accepted (0..15); all other channels ignored
//  CC_ATTACK    7'd73    CC number loading attack_rate
//  CC_DECAY     7'd75    CC number loading decay_rate
//  CC_RELEASE   7'd72    CC number loading release_rate
//  CC_SUSTAIN   7'd70    CC number loading sustain_value
//  DEF_RATE     7'h7F    reset value of attack/decay/release_rate
//  DEF_SUSTAIN  7'h20    reset value of sustain_value
// PORTS
//  clk                 in   1  system clock
//  rst                 in   1  asynchronous reset, ACTIVE-LOW
//  midi_byte           in   8  received MIDI byte
//  midi_valid          in   1  1-cycle strobe, midi_byte valid
//  new_note_pulse      out  1  1-cycle note start to adsr_mngt
//  release_note_pulse  out  1  1-cycle note release to adsr_mngt
//  note                out  7  current note number
//  velocity            out  7  velocity of current note
//  gate                out  1  1 while a note is held
//  attack_rate         out  7  to adsr_mngt
//  decay_rate          out  7  to adsr_mngt
//  release_rate        out  7  to adsr_mngt
//  sustain_value       out  7  to adsr_mngt
// BEHAVIOUR
//  Reset (rst=0):
//   - all outputs 0, except the rate outputs = DEF_RATE and sustain_value = DEF_SUSTAIN
//   - FSM = WAIT_STATUS; running status cleared
//  Byte classes (evaluated only when midi_valid=1):
//   - 0xF8..0xFF realtime: ignored entirely; FSM state and running status untouched
//   - 0xF0..0xF7 system common/SysEx: clears running status; FSM -> WAIT_STATUS
//   - 0x80..0xEF status: latched as running status; FSM -> WAIT_D1
//     (a status byte mid-message aborts the partial message)
//   - 0x00..0x7F data: processed by FSM
//  FSM states:
//   - WAIT_STATUS: data bytes discarded
//   - WAIT_D1: data -> d1 latched; FSM -> WAIT_D2
//   - WAIT_D2: data -> message executed; FSM -> WAIT_D1 (running status reuse)
//   - Program Change (0xC) and Channel Pressure (0xD) take one data byte: WAIT_D1 -> WAIT_D1, no action
//   - Status nibbles 0xA, 0xE: two data bytes consumed, no action
//   - Channel nibble != MIDI_CH: bytes consumed, no action
//  Execution (registered outputs, 1 clk after the completing byte's midi_valid):
//   - Note On (0x9), vel != 0: note=d1, velocity=d2, gate=1, new_note_pulse=1
//     Also applies while gate=1 (legato retrigger); no release pulse is issued.
//   - Note Off (0x8), or Note On with vel=0:
//     if gate=1 and d1==note: gate=0, release_note_pulse=1; otherwise no effect
//   - CC (0xB): d1 matching a CC_* parameter loads the matching output with d2
//     Unmatched CC numbers ignored.
//   - CC 123 (all notes off): if gate=1 -> gate=0, release_note_pulse=1
//  Pulse rules:
//   - each pulse exactly 1 clk wide
//   - new_note_pulse and release_note_pulse never asserted in the same cycle
//  Boundaries:
//   - midi_valid on consecutive clks must be handled; no byte dropped
//   - async reset mid-message: partial message lost; no pulse after reset release
// STRUCTURE
//  - Shared package midi_pkg: status nibble constants (NOTE_OFF=4'h8, NOTE_ON=4'h9, CC=4'hB, PROG=4'hC, CHPRESS=4'hD),
//    FSM state encoding, CC 123 constant.
//  - Natural sub-module midi_byte_parser: status/running-status/FSM logic.
//    Emits msg_valid, msg_type[3:0], d1, d2 for the matching channel.
//  - Top module holds the voice registers and CC registers.
// TESTING
//  1. Reset, then idle -> rate outputs 7'h7F, sustain_value 7'h20, all pulses 0, gate 0.
//  2. Bytes 90 3C 64 -> exactly one new_note_pulse, 1 clk after the 0x64 strobe;
//     note=0x3C, velocity=0x64, gate=1.
//  3. After 2: bytes 3E 50 (running status) -> second new_note_pulse, note=0x3E;
//     then 80 3C 00 -> no release; then 80 3E 00 -> release_note_pulse, gate=0.
//  4. Bytes 90 40 F8 7F -> the F8 is ignored; note=0x40 and pulse generated;
//     then 90 40 F0 00 -> no pulse, FSM in WAIT_STATUS.
//  5. Bytes B0 49 10, B0 46 55, B1 49 00 -> attack_rate=0x10, sustain_value=0x55;
//     the channel-1 CC has no effect.
//  6. Note on; assert rst low between the two data bytes of the next note on
//     -> no pulse after release; outputs at reset values.
//  7. Every scenario: check the pulse-width and pulse-exclusivity assertions.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, controller numbers, parser state
// encoding and the byte classifier used by the parser.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    WAIT_D1     = 2'd1,
    WAIT_D2     = 2'd2
  } parse_state_t;

  typedef enum logic [1:0] {
    BYTE_DATA   = 2'd0,
    BYTE_STATUS = 2'd1,
    BYTE_SYSCOM = 2'd2,
    BYTE_RT     = 2'd3
  } byte_class_t;

  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t c;
    if (!b[7])
      c = BYTE_DATA;
    else if (b[7:3] == 5'b11111)
      c = BYTE_RT;
    else if (b[7:4] == 4'hF)
      c = BYTE_SYSCOM;
    else
      c = BYTE_STATUS;
    return c;
  endfunction

endpackage

// File: rtl/midi_byte_parser.sv
// Running-status MIDI byte parser; emits one completed two-byte channel
// message per cycle for the configured channel.
module midi_byte_parser
  import midi_pkg::*;
#(
  parameter logic [3:0] MIDI_CH = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] midi_byte,
  input  logic       midi_valid,
  output logic       msg_valid,
  output logic [3:0] msg_type,
  output logic [6:0] d1,
  output logic [6:0] d2
);

  parse_state_t state;
  logic [7:0]   run_status;
  logic [6:0]   d1_q;
  byte_class_t  cls;
  logic         one_byte_msg;

  assign cls          = classify(midi_byte);
  assign one_byte_msg = (run_status[7:4] == PROG) || (run_status[7:4] == CHPRESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WAIT_STATUS;
      run_status <= 8'h00;
    end else if (midi_valid) begin
      unique case (cls)
        BYTE_RT: ;
        BYTE_SYSCOM: begin
          state      <= WAIT_STATUS;
          run_status <= 8'h00;
        end
        BYTE_STATUS: begin
          run_status <= midi_byte;
          state      <= WAIT_D1;
        end
        BYTE_DATA: begin
          case (state)
            WAIT_D1: if (!one_byte_msg) state <= WAIT_D2;
            WAIT_D2: state <= WAIT_D1;
            default: ;
          endcase
        end
      endcase
    end
  end

  // First data byte is only meaningful while state says WAIT_D2, so it needs no reset.
  always_ff @(posedge clk) begin
    if (midi_valid && cls == BYTE_DATA && state == WAIT_D1)
      d1_q <= midi_byte[6:0];
  end

  always_comb begin
    msg_valid = midi_valid && (cls == BYTE_DATA) && (state == WAIT_D2)
                && (run_status[3:0] == MIDI_CH);
    msg_type  = run_status[7:4];
    d1        = d1_q;
    d2        = midi_byte[6:0];
  end

endmodule

// File: rtl/midi_voice_trigger.sv
// Monophonic voice front end for adsr_mngt: turns parsed MIDI channel
// messages into note start/release pulses and envelope settings.
module midi_voice_trigger
  import midi_pkg::*;
#(
  parameter logic [3:0] MIDI_CH     = 4'd0,
  parameter logic [6:0] CC_ATTACK   = 7'd73,
  parameter logic [6:0] CC_DECAY    = 7'd75,
  parameter logic [6:0] CC_RELEASE  = 7'd72,
  parameter logic [6:0] CC_SUSTAIN  = 7'd70,
  parameter logic [6:0] DEF_RATE    = 7'h7F,
  parameter logic [6:0] DEF_SUSTAIN = 7'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] midi_byte,
  input  logic       midi_valid,
  output logic       new_note_pulse,
  output logic       release_note_pulse,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic [6:0] attack_rate,
  output logic [6:0] decay_rate,
  output logic [6:0] release_rate,
  output logic [6:0] sustain_value
);

  logic       msg_valid;
  logic [3:0] msg_type;
  logic [6:0] msg_d1;
  logic [6:0] msg_d2;
  logic       start_note;
  logic       stop_note;
  logic       is_cc;

  midi_byte_parser #(
    .MIDI_CH (MIDI_CH)
  ) u_parser (
    .clk        (clk),
    .rst        (rst),
    .midi_byte  (midi_byte),
    .midi_valid (midi_valid),
    .msg_valid  (msg_valid),
    .msg_type   (msg_type),
    .d1         (msg_d1),
    .d2         (msg_d2)
  );

  // Note On with velocity 0 is a Note Off; only the held note may be released.
  always_comb begin
    start_note = 1'b0;
    stop_note  = 1'b0;
    is_cc      = msg_valid && (msg_type == CC);
    if (msg_valid) begin
      if (msg_type == NOTE_ON && msg_d2 != 7'd0)
        start_note = 1'b1;
      else if ((msg_type == NOTE_ON || msg_type == NOTE_OFF) && gate && msg_d1 == note)
        stop_note = 1'b1;
      else if (msg_type == CC && msg_d1 == CC_ALL_NOTES_OFF && gate)
        stop_note = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      new_note_pulse     <= 1'b0;
      release_note_pulse <= 1'b0;
      note               <= 7'd0;
      velocity           <= 7'd0;
      gate               <= 1'b0;
      attack_rate        <= DEF_RATE;
      decay_rate         <= DEF_RATE;
      release_rate       <= DEF_RATE;
      sustain_value      <= DEF_SUSTAIN;
    end else begin
      new_note_pulse     <= start_note;
      release_note_pulse <= stop_note;
      if (start_note) begin
        note     <= msg_d1;
        velocity <= msg_d2;
        gate     <= 1'b1;
      end else if (stop_note) begin
        gate <= 1'b0;
      end
      if (is_cc) begin
        if (msg_d1 == CC_ATTACK)  attack_rate   <= msg_d2;
        if (msg_d1 == CC_DECAY)   decay_rate    <= msg_d2;
        if (msg_d1 == CC_RELEASE) release_rate  <= msg_d2;
        if (msg_d1 == CC_SUSTAIN) sustain_value <= msg_d2;
      end
    end
  end

endmodule
